nvme_rc_cpl_fifo: RTL and testbench

//  Completion buffer downstream of the PCIe RC completion parser (rc_ioq_* outputs).
//  - Accepts one parsed completion per cycle, acks it and stores it in a DEPTH-entry FIFO.
//  - Presents stored completions first-word-fall-through to the NVMe I/O-queue engine.
//  - Drives icq_wfull back to the parser, which uses it as RC AXIS tready backpressure.

---
 rtl/nvme_rc_cpl_fifo.sv | 142 ++++++++++++++
 tb/tb_nvme_rc_cpl_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nvme_rc_cpl_fifo.sv
// nvme_rc_cpl_fifo
//   Completion buffer between the PCIe RC completion parser and the NVMe
//   I/O-queue engine. It accepts and acks one parsed completion per cycle and
//   stores it in a DEPTH-entry FIFO. Stored completions are presented
//   first-word-fall-through on the cq_* side. A registered almost-full flag
//   (icq_wfull) is returned to the parser as AXIS backpressure.
//
//   Optional build macro: NVME_RC_CPL_ERRSTAT_EN
//     When defined, a saturating 16-bit count of error completions is kept.
//     When undefined, cq_err_cnt is tied to zero.
//
// Ports
//   user_clk, user_reset   clock, synchronous active-high reset
//   rc_ioq_*               parsed completion in (data bit 128 ignored)
//   ioq_rc_ack             completion accepted this cycle (combinational)
//   icq_wfull              registered almost-full to parser
//   cq_valid/cq_ready      head handshake towards the I/O-queue engine
//   cq_data/be/tag/status/errcode/err   head fields, zero while empty
//   cq_ovf                 sticky: a completion was dropped at full
//   cq_err_cnt             error-completion count (optional, else 0)
module nvme_rc_cpl_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int AFULL_MARGIN = 4
) (
  input  logic         user_clk,
  input  logic         user_reset,
  input  logic         rc_ioq_valid,
  input  logic [128:0] rc_ioq_data,
  input  logic [7:0]   rc_ioq_be,
  input  logic [7:0]   rc_ioq_tag,
  input  logic         rc_ioq_poison,
  input  logic [3:0]   rc_ioq_errcode,
  input  logic [2:0]   rc_ioq_status,
  output logic         ioq_rc_ack,
  output logic         icq_wfull,
  output logic         cq_valid,
  input  logic         cq_ready,
  output logic [127:0] cq_data,
  output logic [7:0]   cq_be,
  output logic [7:0]   cq_tag,
  output logic [2:0]   cq_status,
  output logic [3:0]   cq_errcode,
  output logic         cq_err,
  output logic         cq_ovf,
  output logic [15:0]  cq_err_cnt
);

  localparam int ENTRY_W = 152;
  localparam logic [ADDR_W:0] FILL_FULL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] FILL_AFULL = (ADDR_W+1)'(DEPTH - AFULL_MARGIN);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    fill;
  logic [ADDR_W:0]    next_fill;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               icq_wfull_q;
  logic               ovf_q;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic               head_poison;
  logic               unused_data_msb;

  assign unused_data_msb = rc_ioq_data[128];

  assign full  = (fill == FILL_FULL);
  assign empty = (fill == '0);

  // Full is judged on the current fill, so a pop in the same cycle does not
  // free a slot for a push until the following cycle.
  assign push = rc_ioq_valid & ~full;
  assign pop  = ~empty & cq_ready;

  assign ioq_rc_ack = push;

  assign wr_entry = {rc_ioq_data[127:0], rc_ioq_be, rc_ioq_tag,
                     rc_ioq_poison, rc_ioq_errcode, rc_ioq_status};

  always_comb begin
    next_fill = fill;
    unique case ({push, pop})
      2'b10:   next_fill = fill + 1'b1;
      2'b01:   next_fill = fill - 1'b1;
      default: next_fill = fill;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      icq_wfull_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fill        <= next_fill;
      icq_wfull_q <= (next_fill >= FILL_AFULL);
      if (rc_ioq_valid && full) ovf_q <= 1'b1;
    end
  end

  // Storage carries no reset; empty masking hides stale contents.
  always_ff @(posedge user_clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

  assign {cq_data, cq_be, cq_tag, head_poison, cq_errcode, cq_status} = head;

  assign cq_err    = head_poison | (|cq_status) | (|cq_errcode);
  assign cq_valid  = ~empty;
  assign icq_wfull = icq_wfull_q;
  assign cq_ovf    = ovf_q;

`ifdef NVME_RC_CPL_ERRSTAT_EN
  logic        in_err;
  logic [15:0] err_cnt_q;

  assign in_err = rc_ioq_poison | (|rc_ioq_status) | (|rc_ioq_errcode);

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      err_cnt_q <= '0;
    end else if (push && in_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign cq_err_cnt = err_cnt_q;
`else
  assign cq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_nvme_rc_cpl_fifo.sv
// Bench for nvme_rc_cpl_fifo: a queue-based reference model checked against
// every DUT output on each falling edge, plus directed literal expectations.
module tb_nvme_rc_cpl_fifo;

  localparam int DEPTH  = 16;
  localparam int AFULL_MARGIN = 4;

  logic         user_clk;
  logic         user_reset;
  logic         rc_ioq_valid;
  logic [128:0] rc_ioq_data;
  logic [7:0]   rc_ioq_be;
  logic [7:0]   rc_ioq_tag;
  logic         rc_ioq_poison;
  logic [3:0]   rc_ioq_errcode;
  logic [2:0]   rc_ioq_status;
  logic         ioq_rc_ack;
  logic         icq_wfull;
  logic         cq_valid;
  logic         cq_ready;
  logic [127:0] cq_data;
  logic [7:0]   cq_be;
  logic [7:0]   cq_tag;
  logic [2:0]   cq_status;
  logic [3:0]   cq_errcode;
  logic         cq_err;
  logic         cq_ovf;
  logic [15:0]  cq_err_cnt;

  nvme_rc_cpl_fifo #(
    .DEPTH(DEPTH),
    .ADDR_W(4),
    .AFULL_MARGIN(AFULL_MARGIN)
  ) dut (
    .user_clk(user_clk),
    .user_reset(user_reset),
    .rc_ioq_valid(rc_ioq_valid),
    .rc_ioq_data(rc_ioq_data),
    .rc_ioq_be(rc_ioq_be),
    .rc_ioq_tag(rc_ioq_tag),
    .rc_ioq_poison(rc_ioq_poison),
    .rc_ioq_errcode(rc_ioq_errcode),
    .rc_ioq_status(rc_ioq_status),
    .ioq_rc_ack(ioq_rc_ack),
    .icq_wfull(icq_wfull),
    .cq_valid(cq_valid),
    .cq_ready(cq_ready),
    .cq_data(cq_data),
    .cq_be(cq_be),
    .cq_tag(cq_tag),
    .cq_status(cq_status),
    .cq_errcode(cq_errcode),
    .cq_err(cq_err),
    .cq_ovf(cq_ovf),
    .cq_err_cnt(cq_err_cnt)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of whole completions.
  logic [151:0] mq[$];
  bit           m_ovf;
  bit           m_wfull;
  int           m_cnt;
  bit           m_pop;
  bit           m_push;
  logic [151:0] m_entry;

  always @(posedge user_clk) begin
    if (user_reset) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_wfull = 1'b0;
      m_cnt   = 0;
    end else begin
      m_pop   = (mq.size() > 0) && cq_ready;
      m_push  = rc_ioq_valid && (mq.size() < DEPTH);
      m_entry = {rc_ioq_data[127:0], rc_ioq_be, rc_ioq_tag,
                 rc_ioq_poison, rc_ioq_errcode, rc_ioq_status};
      if (rc_ioq_valid && mq.size() == DEPTH) m_ovf = 1'b1;
`ifdef NVME_RC_CPL_ERRSTAT_EN
      if (m_push && (rc_ioq_poison || rc_ioq_status != 0 || rc_ioq_errcode != 0)
          && m_cnt < 65535)
        m_cnt++;
`endif
      if (m_pop) void'(mq.pop_front());
      if (m_push) mq.push_back(m_entry);
      m_wfull = (mq.size() >= DEPTH - AFULL_MARGIN);
    end
  end

  logic [151:0] h;
  always @(negedge user_clk) begin
    if (chk_en) begin
      h = (mq.size() > 0) ? mq[0] : '0;
      chk("ack",     160'(ioq_rc_ack), 160'(rc_ioq_valid && mq.size() < DEPTH));
      chk("wfull",   160'(icq_wfull),  160'(m_wfull));
      chk("valid",   160'(cq_valid),   160'(mq.size() > 0));
      chk("data",    160'(cq_data),    160'(h[151:24]));
      chk("be",      160'(cq_be),      160'(h[23:16]));
      chk("tag",     160'(cq_tag),     160'(h[15:8]));
      chk("errcode", 160'(cq_errcode), 160'(h[6:3]));
      chk("status",  160'(cq_status),  160'(h[2:0]));
      chk("err",     160'(cq_err),     160'(h[7] || h[6:3] != 0 || h[2:0] != 0));
      chk("ovf",     160'(cq_ovf),     160'(m_ovf));
      chk("err_cnt", 160'(cq_err_cnt), 160'(m_cnt));
    end
  end

  task automatic tick;
    @(negedge user_clk);
    #1;
  endtask

  task automatic set_push(input logic [7:0] tag, input logic [2:0] st,
                          input logic pois, input logic [3:0] ec);
    rc_ioq_valid   = 1'b1;
    rc_ioq_data    = {tag[0], {16{tag}}};
    rc_ioq_be      = tag ^ 8'hA5;
    rc_ioq_tag     = tag;
    rc_ioq_poison  = pois;
    rc_ioq_errcode = ec;
    rc_ioq_status  = st;
  endtask

  task automatic idle;
    rc_ioq_valid   = 1'b0;
    rc_ioq_poison  = 1'b0;
    rc_ioq_errcode = '0;
    rc_ioq_status  = '0;
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!cq_valid) break;
      cq_ready = 1'b1;
      tick();
      n++;
    end
    cq_ready = 1'b0;
  endtask

  int n;

  initial begin
    user_reset = 1'b1;
    cq_ready   = 1'b0;
    rc_ioq_data = '0;
    rc_ioq_be  = '0;
    rc_ioq_tag = '0;
    idle();
    tick();
    chk_en = 1'b1;
    tick();
    user_reset = 1'b0;
    chk("rst_valid", 160'(cq_valid), 160'(0));
    chk("rst_wfull", 160'(icq_wfull), 160'(0));
    chk("rst_tag",   160'(cq_tag), 160'(0));

    // 1: single push, FWFT next cycle
    set_push(8'h05, 3'd0, 1'b0, 4'd0);
    #1 chk("t1_ack", 160'(ioq_rc_ack), 160'(1));
    tick();
    idle();
    chk("t1_valid", 160'(cq_valid), 160'(1));
    chk("t1_tag",   160'(cq_tag), 160'(8'h05));
    chk("t1_err",   160'(cq_err), 160'(0));
    cq_ready = 1'b1;
    tick();
    cq_ready = 1'b0;

    // 2: fill to 16, almost-full and overflow
    for (int i = 0; i < 16; i++) begin
      set_push(8'(i), 3'd0, 1'b0, 4'd0);
      tick();
      if (i == 10) chk("t2_wfull_11", 160'(icq_wfull), 160'(0));
      if (i == 11) chk("t2_wfull_12", 160'(icq_wfull), 160'(1));
    end
    set_push(8'd16, 3'd0, 1'b0, 4'd0);
    #1 chk("t2_ack_full", 160'(ioq_rc_ack), 160'(0));
    tick();
    chk("t2_ovf", 160'(cq_ovf), 160'(1));

    // 3: push+pop at full -> pop only, then push accepted, ordered drain
    cq_ready = 1'b1;
    #1 chk("t3_ack_full_pop", 160'(ioq_rc_ack), 160'(0));
    tick();
    cq_ready = 1'b0;
    chk("t3_ack_after", 160'(ioq_rc_ack), 160'(1));
    tick();
    idle();
    cq_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("t3_order", 160'(cq_tag), 160'(8'(i)));
      tick();
    end
    cq_ready = 1'b0;
    chk("t3_empty",     160'(cq_valid), 160'(0));
    chk("t3_empty_tag", 160'(cq_tag), 160'(0));

    // 4: steady state at fill 5
    for (int i = 0; i < 5; i++) begin
      set_push(8'(8'h20 + i), 3'd0, 1'b0, 4'd0);
      tick();
    end
    cq_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_push(8'(8'h25 + i), 3'd0, 1'b0, 4'd0);
      #1 chk("t4_ack", 160'(ioq_rc_ack), 160'(1));
      tick();
    end
    idle();
    cq_ready = 1'b0;
    chk("t4_head", 160'(cq_tag), 160'(8'h48));
    drain(n);
    chk("t4_fill", 160'(n), 160'(5));

    // 5: error flavours
    set_push(8'h30, 3'b001, 1'b0, 4'h0); tick();
    set_push(8'h31, 3'b000, 1'b1, 4'h0); tick();
    set_push(8'h32, 3'b000, 1'b0, 4'h2); tick();
    idle();
`ifdef NVME_RC_CPL_ERRSTAT_EN
    chk("t5_cnt", 160'(cq_err_cnt), 160'(3));
`else
    chk("t5_cnt", 160'(cq_err_cnt), 160'(0));
`endif
    cq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_err", 160'(cq_err), 160'(1));
      tick();
    end
    cq_ready = 1'b0;

    // 6: reset with fill 9
    for (int i = 0; i < 9; i++) begin
      set_push(8'(8'h40 + i), 3'd0, 1'b0, 4'd0);
      tick();
    end
    idle();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    chk("t6_valid", 160'(cq_valid), 160'(0));
    chk("t6_wfull", 160'(icq_wfull), 160'(0));
    chk("t6_ovf",   160'(cq_ovf), 160'(0));
    set_push(8'h77, 3'd0, 1'b0, 4'd0);
    tick();
    idle();
    chk("t6_tag",   160'(cq_tag), 160'(8'h77));
    chk("t6_valid2", 160'(cq_valid), 160'(1));
    drain(n);
    chk("t6_fill", 160'(n), 160'(1));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
